// File: rtl/offnariscv_pkg.sv
// Shared types for the memory-port arbiter.
// Holds the read/write FSM state encodings and the requester count.
package offnariscv_pkg;

  localparam int NUM_MEM_REQ = 2;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } arb_rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_REQ,
    WR_RESP
  } arb_wr_state_e;

endpackage

// File: rtl/ace_if.sv
// ACE bus bundle: AR/R/AW/W/B plus snoop AC/CR/CD and RACK/WACK.
// Modport m is the bus master side, s is the slave side.
interface ace_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [3:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  logic              acvalid;
  logic              acready;
  logic [ADDR_W-1:0] acaddr;
  logic [3:0]        acsnoop;

  logic       crvalid;
  logic       crready;
  logic [4:0] crresp;

  logic              cdvalid;
  logic              cdready;
  logic [DATA_W-1:0] cddata;
  logic              cdlast;

  logic rack;
  logic wack;

  modport m (
    output arvalid, araddr, arid, arlen, arsize,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    input  acvalid, acaddr, acsnoop,
    output acready,
    output crvalid, crresp,
    input  crready,
    output cdvalid, cddata, cdlast,
    input  cdready,
    output rack, wack
  );

  modport s (
    input  arvalid, araddr, arid, arlen, arsize,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    output acvalid, acaddr, acsnoop,
    input  acready,
    input  crvalid, crresp,
    output crready,
    input  cdvalid, cddata, cdlast,
    output cdready,
    input  rack, wack
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way arbiter with a last-granted pointer for tie breaking.
// Ports: req, update (commit gnt_idx), rr_enable -> gnt_idx, any_req.
module rr_arbiter2
  import offnariscv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MEM_REQ-1:0] req,
  input  logic                   update,
  input  logic                   rr_enable,
  output logic                   gnt_idx,
  output logic                   any_req
);

  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (update) begin
      ptr_q <= gnt_idx;
    end
  end

  // On a tie the requester that did not win last time goes next;
  // with rr disabled the LSU (index 1) always wins.
  always_comb begin
    gnt_idx = req[1];
    if (&req) begin
      gnt_idx = rr_enable ? ~ptr_q : 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ACE port between ifu (0) and lsu (1); rd/wr arbitrated apart.
// Ports: clk, rst, ifu/lsu (s), mem (m), rd/wr_grant, rd/wr_busy.
module mem_port_arbiter
  import offnariscv_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  ace_if.s     ifu_ace_if,
  ace_if.s     lsu_ace_if,
  ace_if.m     mem_ace_if,
  output logic rd_grant,
  output logic wr_grant,
  output logic rd_busy,
  output logic wr_busy
);

  arb_rd_state_e rd_q, rd_d;
  arb_wr_state_e wr_q, wr_d;
  logic rd_gnt_q, rd_gnt_d;
  logic wr_gnt_q, wr_gnt_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic rd_upd, wr_upd;
  logic rd_idx, rd_any;
  logic wr_idx, wr_any;

  // The pointer is only looked at in idle, so committing it together
  // with the registered grant behaves the same as at completion.
  rr_arbiter2 u_rd_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({lsu_ace_if.arvalid, ifu_ace_if.arvalid}),
    .update   (rd_upd),
    .rr_enable(RR_ENABLE),
    .gnt_idx  (rd_idx),
    .any_req  (rd_any)
  );

  rr_arbiter2 u_wr_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({lsu_ace_if.awvalid, ifu_ace_if.awvalid}),
    .update   (wr_upd),
    .rr_enable(RR_ENABLE),
    .gnt_idx  (wr_idx),
    .any_req  (wr_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= RD_IDLE;
      wr_q      <= WR_IDLE;
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rd_gnt_q  <= rd_gnt_d;
      wr_gnt_q  <= wr_gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read path
  logic rd_ar_en, rd_r_en;
  logic sel_rready, mem_rready;

  assign rd_ar_en   = (rd_q == RD_ADDR);
  assign rd_r_en    = (rd_q == RD_DATA);
  assign sel_rready = rd_gnt_q ? lsu_ace_if.rready
                               : ifu_ace_if.rready;
  assign mem_rready = rd_r_en & sel_rready;

  always_comb begin
    rd_d     = rd_q;
    rd_gnt_d = rd_gnt_q;
    rd_upd   = 1'b0;
    unique case (rd_q)
      RD_IDLE: begin
        if (rd_any) begin
          rd_d     = RD_ADDR;
          rd_gnt_d = rd_idx;
          rd_upd   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (mem_ace_if.arready) rd_d = RD_DATA;
      end
      RD_DATA: begin
        if (mem_ace_if.rvalid & mem_rready & mem_ace_if.rlast)
          rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  assign mem_ace_if.arvalid = rd_ar_en;
  assign mem_ace_if.araddr  = rd_gnt_q ? lsu_ace_if.araddr
                                       : ifu_ace_if.araddr;
  assign mem_ace_if.arid    = rd_gnt_q ? lsu_ace_if.arid
                                       : ifu_ace_if.arid;
  assign mem_ace_if.arlen   = rd_gnt_q ? lsu_ace_if.arlen
                                       : ifu_ace_if.arlen;
  assign mem_ace_if.arsize  = rd_gnt_q ? lsu_ace_if.arsize
                                       : ifu_ace_if.arsize;
  assign mem_ace_if.rready  = mem_rready;

  assign ifu_ace_if.arready = rd_ar_en & ~rd_gnt_q & mem_ace_if.arready;
  assign lsu_ace_if.arready = rd_ar_en &  rd_gnt_q & mem_ace_if.arready;
  assign ifu_ace_if.rvalid  = rd_r_en & ~rd_gnt_q & mem_ace_if.rvalid;
  assign lsu_ace_if.rvalid  = rd_r_en &  rd_gnt_q & mem_ace_if.rvalid;

  assign ifu_ace_if.rdata = mem_ace_if.rdata;
  assign ifu_ace_if.rresp = mem_ace_if.rresp;
  assign ifu_ace_if.rid   = mem_ace_if.rid;
  assign ifu_ace_if.rlast = mem_ace_if.rlast;
  assign lsu_ace_if.rdata = mem_ace_if.rdata;
  assign lsu_ace_if.rresp = mem_ace_if.rresp;
  assign lsu_ace_if.rid   = mem_ace_if.rid;
  assign lsu_ace_if.rlast = mem_ace_if.rlast;

  // Write path: AW and W complete independently inside WR_REQ
  logic wr_aw_en, wr_w_en, wr_b_en;
  logic sel_wvalid, sel_wlast, sel_bready;
  logic mem_wvalid, mem_bready;
  logic aw_hs, w_last_hs;

  assign wr_aw_en   = (wr_q == WR_REQ) & ~aw_done_q;
  assign wr_w_en    = (wr_q == WR_REQ) & ~w_done_q;
  assign wr_b_en    = (wr_q == WR_RESP);
  assign sel_wvalid = wr_gnt_q ? lsu_ace_if.wvalid
                               : ifu_ace_if.wvalid;
  assign sel_wlast  = wr_gnt_q ? lsu_ace_if.wlast
                               : ifu_ace_if.wlast;
  assign sel_bready = wr_gnt_q ? lsu_ace_if.bready
                               : ifu_ace_if.bready;
  assign mem_wvalid = wr_w_en & sel_wvalid;
  assign mem_bready = wr_b_en & sel_bready;
  assign aw_hs      = wr_aw_en & mem_ace_if.awready;
  assign w_last_hs  = mem_wvalid & mem_ace_if.wready & sel_wlast;

  always_comb begin
    wr_d      = wr_q;
    wr_gnt_d  = wr_gnt_q;
    wr_upd    = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (wr_q)
      WR_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (wr_any) begin
          wr_d     = WR_REQ;
          wr_gnt_d = wr_idx;
          wr_upd   = 1'b1;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d & w_done_d) begin
          wr_d      = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (mem_ace_if.bvalid & mem_bready) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  assign mem_ace_if.awvalid = wr_aw_en;
  assign mem_ace_if.awaddr  = wr_gnt_q ? lsu_ace_if.awaddr
                                       : ifu_ace_if.awaddr;
  assign mem_ace_if.awid    = wr_gnt_q ? lsu_ace_if.awid
                                       : ifu_ace_if.awid;
  assign mem_ace_if.awlen   = wr_gnt_q ? lsu_ace_if.awlen
                                       : ifu_ace_if.awlen;
  assign mem_ace_if.awsize  = wr_gnt_q ? lsu_ace_if.awsize
                                       : ifu_ace_if.awsize;
  assign mem_ace_if.wvalid  = mem_wvalid;
  assign mem_ace_if.wdata   = wr_gnt_q ? lsu_ace_if.wdata
                                       : ifu_ace_if.wdata;
  assign mem_ace_if.wstrb   = wr_gnt_q ? lsu_ace_if.wstrb
                                       : ifu_ace_if.wstrb;
  assign mem_ace_if.wlast   = sel_wlast;
  assign mem_ace_if.bready  = mem_bready;

  assign ifu_ace_if.awready = wr_aw_en & ~wr_gnt_q & mem_ace_if.awready;
  assign lsu_ace_if.awready = wr_aw_en &  wr_gnt_q & mem_ace_if.awready;
  assign ifu_ace_if.wready  = wr_w_en & ~wr_gnt_q & mem_ace_if.wready;
  assign lsu_ace_if.wready  = wr_w_en &  wr_gnt_q & mem_ace_if.wready;
  assign ifu_ace_if.bvalid  = wr_b_en & ~wr_gnt_q & mem_ace_if.bvalid;
  assign lsu_ace_if.bvalid  = wr_b_en &  wr_gnt_q & mem_ace_if.bvalid;

  assign ifu_ace_if.bresp = mem_ace_if.bresp;
  assign ifu_ace_if.bid   = mem_ace_if.bid;
  assign lsu_ace_if.bresp = mem_ace_if.bresp;
  assign lsu_ace_if.bid   = mem_ace_if.bid;

  // Snoop channels are not supported: everything tied off
  assign ifu_ace_if.acvalid = 1'b0;
  assign ifu_ace_if.acaddr  = '0;
  assign ifu_ace_if.acsnoop = '0;
  assign ifu_ace_if.crready = 1'b0;
  assign ifu_ace_if.cdready = 1'b0;
  assign lsu_ace_if.acvalid = 1'b0;
  assign lsu_ace_if.acaddr  = '0;
  assign lsu_ace_if.acsnoop = '0;
  assign lsu_ace_if.crready = 1'b0;
  assign lsu_ace_if.cdready = 1'b0;

  assign mem_ace_if.acready = 1'b0;
  assign mem_ace_if.crvalid = 1'b0;
  assign mem_ace_if.crresp  = '0;
  assign mem_ace_if.cdvalid = 1'b0;
  assign mem_ace_if.cddata  = '0;
  assign mem_ace_if.cdlast  = 1'b0;
  assign mem_ace_if.rack    = 1'b0;
  assign mem_ace_if.wack    = 1'b0;

  logic unused_snoop;
  assign unused_snoop = ^{
    mem_ace_if.acvalid, mem_ace_if.acaddr, mem_ace_if.acsnoop,
    mem_ace_if.crready, mem_ace_if.cdready,
    ifu_ace_if.crvalid, ifu_ace_if.crresp, ifu_ace_if.cdvalid,
    ifu_ace_if.cddata, ifu_ace_if.cdlast,
    ifu_ace_if.rack, ifu_ace_if.wack,
    lsu_ace_if.crvalid, lsu_ace_if.crresp, lsu_ace_if.cdvalid,
    lsu_ace_if.cddata, lsu_ace_if.cdlast,
    lsu_ace_if.rack, lsu_ace_if.wack
  };

  assign rd_grant = rd_gnt_q;
  assign wr_grant = wr_gnt_q;
  assign rd_busy  = (rd_q != RD_IDLE);
  assign wr_busy  = (wr_q != WR_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream ACE memory port between two upstream masters: instruction fetch (requester 0) and the LSU (requester 1).
- Sits between the core front/back end and the L2/memory interconnect.
- Read and write paths are arbitrated independently. Each path allows one outstanding transaction and holds its grant until the response handshake completes.
- Snoop channels are not supported yet; they are tied off.

Parameters:
- RR_ENABLE, 1, 1 = round-robin on ties; 0 = fixed priority, LSU (requester 1) always wins ties.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ifu_ace_if  ace_if.s  interface  requester 0 (instruction fetch)
- lsu_ace_if  ace_if.s  interface  requester 1 (LSU)
- mem_ace_if  ace_if.m  interface  shared downstream port; ADDR/DATA widths identical to both requesters
- rd_grant  output  1  current read owner (0 = ifu, 1 = lsu); valid while rd_busy
- wr_grant  output  1  current write owner; valid while wr_busy
- rd_busy  output  1  read FSM not in RD_IDLE
- wr_busy  output  1  write FSM not in WR_IDLE

Behaviour:
- Reset values:
  - Read FSM = RD_IDLE; write FSM = WR_IDLE.
  - rd_grant = wr_grant = 0; rd_busy = wr_busy = 0.
  - Round-robin pointers (last granted) = 0, so the LSU wins the first tie.
  - mem arvalid/awvalid/wvalid/rready/bready = 0.
  - All upstream arready/awready/wready/rvalid/bvalid = 0.
- Reset mid-transaction: both FSMs are forced to idle and in-flight state is dropped. The rest of the system resets in the same cycle.
- Read FSM: RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE.
  - RD_IDLE: sample the arvalid lines of both requesters. If any is set, register the grant and go to RD_ADDR.
  - Arbitration: one requester valid -> it wins. Both valid -> the one not last granted wins (RR_ENABLE=1), or the LSU wins (RR_ENABLE=0).
  - RD_ADDR: all mem AR fields are muxed combinationally from the granted requester. The granted requester sees arready = mem arready. On the AR handshake -> RD_DATA.
  - RD_DATA: mem R channel is routed to the granted requester (rvalid, rdata, rresp, rid, rlast); mem rready = granted rready.
  - On an R handshake with rlast=1 -> RD_IDLE, and the pointer updates to the granted index.
  - Latency: one bubble cycle for arbitration. AR reaches mem at the earliest one cycle after the requester raises arvalid. No combinational path from upstream arvalid to mem arvalid.
- Write FSM: WR_IDLE -> WR_REQ -> WR_RESP -> WR_IDLE.
  - Arbitration is on awvalid, using the same rules and its own pointer.
  - WR_REQ: AW and W are forwarded independently from the granted requester. Internal flags aw_done and w_done record the AW handshake and the W handshake with wlast.
  - When both flags are set (same cycle allowed) -> WR_RESP.
  - WR_RESP: mem B is routed to the granted requester. On the B handshake -> WR_IDLE and the pointer updates.
- Non-granted or idle requester:
  - arready, awready and wready stay 0.
  - rvalid and bvalid stay 0.
  - rdata, bresp and other response fields are driven with mem values and are don't-care.
- Concurrency: read and write paths operate simultaneously, including the same requester on both. No ordering is enforced between paths; the LSU serialises its own load after store by waiting for B.
- Requesters must hold valid and payload stable until handshake; the arbiter never drops an asserted grant.
- Tie-offs:
  - Upstream acvalid = 0; upstream crready/cdready = 0.
  - mem acready = 0, crvalid = 0, cdvalid = 0, crresp/cddata/cdlast = 0.
  - mem rack/wack = 0.
- IDs and sizes pass through unmodified; only one transaction is outstanding per path, so no ID remapping is needed.

Decomposition:
- In offnariscv_pkg: arb_rd_state_e {RD_IDLE, RD_ADDR, RD_DATA}, arb_wr_state_e {WR_IDLE, WR_REQ, WR_RESP}, and localparam NUM_MEM_REQ = 2.
- One sub-module, rr_arbiter2:
  - Inputs: clk, rst, req[1:0], update, rr_enable.
  - Outputs: gnt_idx and any_req.
  - Holds the last-granted pointer.
  - Instantiated twice, once for the read path and once for the write path.

Test Plan:
- Single LSU load: lsu arvalid at cycle 0, araddr=0x8000_0040; mem arready=1 -> mem arvalid at cycle 1 with araddr 0x8000_0040. mem R rdata=0xDEADBEEF, rlast=1 -> lsu rvalid; ifu rvalid stays 0; rd_busy=0 the cycle after.
- Read tie, RR_ENABLE=1: both arvalid at cycle 0 after reset -> LSU granted first, ifu second. Repeat both-valid 4 times -> grants alternate 1,0,1,0.
- Read tie, RR_ENABLE=0: both arvalid continuously for 3 transactions -> all grants to LSU.
- Concurrent paths: ifu read (araddr=0x1000) and LSU store (awaddr=0x2000, wdata=0x12345678, wstrb=0xF) in the same cycle -> both forwarded in cycle 1. B arrives before R -> each response goes only to its owner.
- AW/W skew: mem awready=1 at cycle 1 but wready held 0 until cycle 5 -> state stays WR_REQ; mem bready rises only after the W handshake; lsu bvalid on mem bvalid.
- Reset during RD_DATA: assert rst with mem rvalid pending -> next cycle rd_busy=0, mem rready=0, all upstream rvalid=0. A fresh lsu arvalid afterwards is granted normally.
